alu_op_decoder: RTL

//  Producer side of the 4-bit ALU Operation code: decodes ALUOp/funct3/funct7 from the

---
 rtl/alu_op_decoder.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/alu_op_decoder.sv
// Decodes ALUOp/funct3/funct7 into the ALU Operation code and registers it behind a
// 2-entry skid buffer with valid/ready on both sides. The in_ready output is registered.
//
// state   | meaning
// S_EMPTY | nothing buffered, out_valid low
// S_ONE   | output register holds a request
// S_TWO   | output and skid registers both hold requests, in_ready low
module alu_op_decoder #(
  parameter int OPCODE_LENGTH = 4,
  parameter int TAG_W         = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               alu_op,
  input  logic [2:0]               funct3,
  input  logic [6:0]               funct7,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OPCODE_LENGTH-1:0] operation,
  output logic                     illegal,
  output logic [TAG_W-1:0]         out_tag
);

  localparam logic [OPCODE_LENGTH-1:0] OP_AND = OPCODE_LENGTH'(4'b0000);
  localparam logic [OPCODE_LENGTH-1:0] OP_OR  = OPCODE_LENGTH'(4'b0001);
  localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(4'b0010);
  localparam logic [OPCODE_LENGTH-1:0] OP_SLL = OPCODE_LENGTH'(4'b0100);
  localparam logic [OPCODE_LENGTH-1:0] OP_SRL = OPCODE_LENGTH'(4'b0101);
  localparam logic [OPCODE_LENGTH-1:0] OP_SRA = OPCODE_LENGTH'(4'b0111);
  localparam logic [OPCODE_LENGTH-1:0] OP_EQ  = OPCODE_LENGTH'(4'b1000);
  localparam logic [OPCODE_LENGTH-1:0] OP_ILL = OPCODE_LENGTH'(4'b1111);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  state_t                     state, state_nx;
  logic [OPCODE_LENGTH-1:0]   dec_op;
  logic                       dec_ill;
  logic                       is_rtype;
  logic                       f7_std;
  logic                       in_xfer, out_xfer;
  logic                       load_out_in, load_out_skid, load_skid;
  logic [OPCODE_LENGTH-1:0]   skid_op;
  logic                       skid_ill;
  logic [TAG_W-1:0]           skid_tag;

  assign out_valid = (state != S_EMPTY);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  // Anything not explicitly matched stays illegal with operation 1111.
  always_comb begin
    dec_op   = OP_ILL;
    dec_ill  = 1'b1;
    is_rtype = (alu_op == 2'b10);
    f7_std   = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
    case (alu_op)
      2'b00: begin
        dec_op  = OP_ADD;
        dec_ill = 1'b0;
      end
      2'b01: begin
        if (funct3 == 3'b000) begin
          dec_op  = OP_EQ;
          dec_ill = 1'b0;
        end
      end
      default: begin
        if (!is_rtype || f7_std) begin
          case (funct3)
            3'b000: begin
              if (!is_rtype || !funct7[5]) begin
                dec_op  = OP_ADD;
                dec_ill = 1'b0;
              end
            end
            3'b111: begin
              dec_op  = OP_AND;
              dec_ill = 1'b0;
            end
            3'b110: begin
              dec_op  = OP_OR;
              dec_ill = 1'b0;
            end
            3'b001: begin
              if (is_rtype || (funct7 == 7'b0000000)) begin
                dec_op  = OP_SLL;
                dec_ill = 1'b0;
              end
            end
            3'b101: begin
              if (f7_std) begin
                dec_op  = funct7[5] ? OP_SRA : OP_SRL;
                dec_ill = 1'b0;
              end
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  always_comb begin
    state_nx      = state;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state)
      S_EMPTY: begin
        if (in_xfer) begin
          state_nx    = S_ONE;
          load_out_in = 1'b1;
        end
      end
      S_ONE: begin
        if (in_xfer && out_xfer) begin
          load_out_in = 1'b1;
        end else if (in_xfer) begin
          state_nx  = S_TWO;
          load_skid = 1'b1;
        end else if (out_xfer) begin
          state_nx = S_EMPTY;
        end
      end
      S_TWO: begin
        if (out_xfer) begin
          state_nx      = S_ONE;
          load_out_skid = 1'b1;
        end
      end
      default: state_nx = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_EMPTY;
      in_ready  <= 1'b0;
      operation <= '0;
      illegal   <= 1'b0;
      out_tag   <= '0;
      skid_op   <= '0;
      skid_ill  <= 1'b0;
      skid_tag  <= '0;
    end else begin
      state    <= state_nx;
      in_ready <= (state_nx != S_TWO);
      if (load_out_in) begin
        operation <= dec_op;
        illegal   <= dec_ill;
        out_tag   <= in_tag;
      end else if (load_out_skid) begin
        operation <= skid_op;
        illegal   <= skid_ill;
        out_tag   <= skid_tag;
      end
      if (load_skid) begin
        skid_op  <= dec_op;
        skid_ill <= dec_ill;
        skid_tag <= in_tag;
      end
    end
  end

endmodule
